// File: rtl/fn3_vector_checker.sv
// fn3_vector_checker: drives all 8 vectors {x1,x2,x3} into a 3-input
// combinational block, samples f after a settle interval per vector and
// compares against the EXPECTED truth table. Reports pass, error count and
// the first failing vector index.
module fn3_vector_checker #(
  parameter logic [7:0] EXPECTED      = 8'h1D,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_err_valid,
  output logic [2:0] first_err_idx
);

  // A settle of 0 behaves like 1; the counter wraps at SETTLE_LAST.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES <= 1) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] x_q, x_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic       fev_q, fev_d;
  logic [2:0] fei_q, fei_d;
  logic       mismatch;

  assign mismatch = (f != EXPECTED[idx_q]);

  // Next-state: sweep sequencing, sampling and result bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort here since abort only acts in RUN
        if (start) begin
          state_d = S_RUN;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          x_d     = 3'd0;
          err_d   = 4'd0;
          fev_d   = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          // abort beats a coincident sample: nothing is recorded this edge
          state_d = S_IDLE;
          busy_d  = 1'b0;
          x_d     = 3'd0;
          pass_d  = 1'b0;
          cnt_d   = 4'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = 4'd0;
          if (mismatch) begin
            err_d = err_q + 4'd1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = idx_q;
            end
          end
          if (idx_q == 3'd7) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            x_d     = 3'd0;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);   // includes vector 7's result
          end else begin
            idx_d = idx_q + 3'd1;
            x_d   = idx_q + 3'd1;        // next vector with no gap
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      x_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fev_q   <= 1'b0;
      fei_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
    end
  end

  assign x1              = x_q[2];
  assign x2              = x_q[1];
  assign x3              = x_q[0];
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: doc/fn3_vector_checker.md
Name: fn3_vector_checker

Overview:
- Self-checking stimulus driver/response checker: the other end of the 3-input combinational example blocks (x1, x2, x3 -> f).
- On start, sweeps all 8 input vectors into the block under test, samples f after a settle interval, and compares it against a parameterised truth table.
- Reports pass/fail, error count and first failing vector.
- Used in the example benches and for on-chip self-test of the example logic.

Parameters:
- EXPECTED, 8'h1D, expected f for vector index i = {x1,x2,x3} at bit i. The default is the mux-then-zero-detect function: f = ~(x2 ? x1 : x3).
- SETTLE_CYCLES, 2, clock cycles each vector is held before f is sampled. Legal range 1..15. A value of 0 is treated as 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a sweep; ignored unless idle
- abort  input  1  cancels a sweep in progress; ignored when idle
- f  input  1  response from the block under test
- x1  output  1  stimulus bit 2 of vector index
- x2  output  1  stimulus bit 1 of vector index
- x3  output  1  stimulus bit 0 of vector index
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse: sweep completed (not asserted on abort)
- pass  output  1  last completed sweep had zero mismatches
- err_count  output  4  mismatches in current/last sweep, 0..8
- first_err_valid  output  1  at least one mismatch recorded
- first_err_idx  output  3  vector index of first mismatch

Behaviour:
- Reset (async, rst_n=0) sets all outputs to 0, clears state to IDLE, index 0 and settle counter 0. Release is synchronous to clk; no output changes until the first edge with rst_n=1.
- All outputs are registered.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - x1/x2/x3 = 0.
  - start=1 at edge T: idx<=0, settle counter<=0, err_count<=0, first_err_valid<=0, pass<=0, busy<=1, go to RUN.
  - Vector 0 is visible on x1..x3 from T+1.
- RUN:
  - {x1,x2,x3} = idx. The settle counter increments every cycle.
  - When counter == SETTLE_CYCLES-1, f is sampled at that edge and the counter returns to 0.
  - Mismatch when f != EXPECTED[idx]. On mismatch: err_count increments. If first_err_valid=0, first_err_idx<=idx and first_err_valid<=1.
  - If idx<7, idx increments at the same edge, so the next vector is applied with no gap.
  - If idx==7, go to FINISH.
  - Sample k occurs at edge T+(k+1)*SETTLE_CYCLES.
- FINISH (one cycle):
  - done=1, busy=0, x1..x3=0.
  - pass=1 iff the final err_count==0, where final includes the mismatch from vector 7.
  - Return to IDLE next edge.
  - done is high exactly in the cycle after the last sample edge.
- Abort:
  - abort=1 in RUN: go to IDLE at that edge, busy<=0, x<=0, no sample taken that edge, done not pulsed, pass<=0.
  - err_count and first_err fields keep their partial values.
  - If abort and a sample edge coincide, abort wins.
- start while busy or in FINISH: ignored, no restart.
- start and abort together in IDLE: start accepted.
- Results hold in IDLE until the next accepted start clears them.
- err_count maximum is 8; no overflow is possible.
- f is assumed combinationally derived from x1..x3 in the clk domain; no synchroniser.
- Reset mid-sweep: immediate return to reset values, no done pulse.

Test Plan:
- Correct DUT (f = ~(x2?x1:x3)), SETTLE_CYCLES=2, start at edge T -> x sequence 0..7, each held 2 cycles; done pulse at T+17; pass=1; err_count=0; first_err_valid=0.
- f tied to 0 -> mismatches at idx 0,2,3,4; err_count=4; first_err_idx=0; pass=0.
- f = ~(x2?x1:x3) except forced 1 at idx 6 -> err_count=1; first_err_idx=6; first_err_valid=1; pass=0.
- start pulsed again at T+5 mid-sweep -> ignored, single done at T+17. abort at T+7 in a second run -> busy=0 next cycle, no done, err_count keeps partial value, x=000.
- SETTLE_CYCLES=1 -> a new vector every cycle; done at T+9. SETTLE_CYCLES=0 -> identical timing to 1.
- rst_n low asynchronously at T+6 mid-sweep -> all outputs 0 immediately, no done. After release, start produces a clean full sweep with pass=1.
